// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and
// registers {pc, inst} into a one-entry valid/ready buffer; handles redirect, halt and fault.
module inst_fetch #(
  parameter int                 ADDR_W    = 16,
  parameter int                 MEM_BYTES = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [3:0]         HALT_OP   = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_inst,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic xfer;
  logic want_load;
  logic bad_pc;
  logic redir_take;

  assign xfer       = out_valid_q && out_ready;
  assign want_load  = (state_q == ST_FETCH) && run && (!out_valid_q || out_ready) && !redir_valid;
  assign bad_pc     = pc_q[0] || (pc_q > LAST_PC);
  assign redir_take = redir_valid && (state_q != ST_FAULT);

  // NOTE: every variable gets its hold value first so no path through the block infers a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;

    if (redir_take) begin
      // A same-cycle transfer still completes; otherwise the buffered entry is dropped.
      pc_d        = redir_pc;
      out_valid_d = 1'b0;
      state_d     = ST_FETCH;
      halted_d    = 1'b0;
    end else if (want_load && bad_pc) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      if (xfer) out_valid_d = 1'b0;
    end else if (want_load) begin
      out_inst_d  = imem_inst;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + ADDR_W'(2);
      if (imem_inst[15:12] == HALT_OP) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle vector table plus a scoreboard of delivered instructions.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] imem_addr;
  logic [15:0] imem_inst;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic        halted;
  logic        fault;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .halted      (halted),
    .fault       (fault)
  );

  logic [15:0] mem [32];
  assign imem_inst = mem[imem_addr[5:1]];

  typedef struct {
    logic        run, rdy, rv;
    logic [15:0] rpc;
    logic        push;
    logic        ev;
    logic [15:0] epc, einst, eaddr;
    logic        eh, ef;
  } vec_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [15:0] rpc,
                              input logic push, input logic ev, input logic [15:0] epc,
                              input logic [15:0] einst, input logic [15:0] eaddr,
                              input logic eh, input logic ef);
    vec_t v;
    v.run = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.push = push; v.ev = ev;
    v.epc = epc; v.einst = einst; v.eaddr = eaddr; v.eh = eh; v.ef = ef;
    return v;
  endfunction

  // Drive one cycle at the falling edge, score any transfer, then check post-edge state.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    run = v.run; out_ready = v.rdy; redir_valid = v.rv; redir_pc = v.rpc;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_unexpected"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({tag, "_xfer_pc"}, {16'd0, out_pc}, {16'd0, e.pc});
        check({tag, "_xfer_inst"}, {16'd0, out_inst}, {16'd0, e.inst});
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (v.push) sb.push_back('{pc: v.epc, inst: v.einst});
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v.ev});
    check({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, v.eaddr});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, v.eh});
    check({tag, "_fault"}, {31'd0, fault}, {31'd0, v.ef});
    if (v.ev) begin
      check({tag, "_pc"}, {16'd0, out_pc}, {16'd0, v.epc});
      check({tag, "_inst"}, {16'd0, out_inst}, {16'd0, v.einst});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hF025;

    //            run rdy rv rpc      push ev  epc      einst     eaddr    h  f
    tbl.push_back(mk(1, 1, 0, 16'h0,  1, 1, 16'h0,  16'h1234, 16'h2,  0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  1, 1, 16'h2,  16'h5678, 16'h4,  0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0,  0, 1, 16'h2,  16'h5678, 16'h4,  0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0,  0, 1, 16'h2,  16'h5678, 16'h4,  0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0,  0, 1, 16'h2,  16'h5678, 16'h4,  0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  0, 1, 16'h4,  16'h9ABC, 16'h6,  0, 0));
    tbl.push_back(mk(1, 0, 1, 16'h10, 0, 0, 16'h0,  16'h0,    16'h10, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0,  1, 1, 16'h10, 16'h1008, 16'h12, 0, 0));
    tbl.push_back(mk(1, 1, 1, 16'h10, 0, 0, 16'h0,  16'h0,    16'h10, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  1, 1, 16'h10, 16'h1008, 16'h12, 0, 0));
    tbl.push_back(mk(1, 1, 1, 16'h6,  0, 0, 16'h0,  16'h0,    16'h6,  0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0,  1, 1, 16'h6,  16'hF025, 16'h8,  1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0,  0, 1, 16'h6,  16'hF025, 16'h8,  1, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'h8,  1, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'h8,  1, 0));
    tbl.push_back(mk(1, 1, 1, 16'h0,  0, 0, 16'h0,  16'h0,    16'h0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  1, 1, 16'h0,  16'h1234, 16'h2,  0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'h2,  0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'h2,  0, 0));
    tbl.push_back(mk(1, 1, 1, 16'h3,  0, 0, 16'h0,  16'h0,    16'h3,  0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'h3,  0, 1));
    tbl.push_back(mk(1, 1, 1, 16'h0,  0, 0, 16'h0,  16'h0,    16'h3,  0, 1));

    rst_n = 1'b0; run = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", {16'd0, out_inst}, 32'd0);
    check("rst_pc", {16'd0, out_pc}, 32'd0);
    check("rst_addr", {16'd0, imem_addr}, 32'd0);
    check("rst_flags", {30'd0, halted, fault}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset out of FAULT, mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    check("arst_fault", {31'd0, fault}, 32'd0);
    check("arst_addr", {16'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset with a buffered instruction pending (it is lost).
    step(mk(1, 0, 0, 16'h0, 0, 1, 16'h0, 16'h1234, 16'h2, 0, 0), "pre_arst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pc", {16'd0, imem_addr}, 32'd0);
    check("arst_outpc", {16'd0, out_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch running off the end of memory.
    step(mk(1, 1, 1, 16'd60, 0, 0, 16'h0,  16'h0,    16'd60, 0, 0), "end0");
    step(mk(1, 1, 0, 16'h0,  1, 1, 16'd60, 16'h101E, 16'd62, 0, 0), "end1");
    step(mk(1, 1, 0, 16'h0,  1, 1, 16'd62, 16'h101F, 16'd64, 0, 0), "end2");
    step(mk(1, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'd64, 0, 1), "end3");
    step(mk(1, 1, 0, 16'h0,  0, 0, 16'h0,  16'h0,    16'd64, 0, 1), "end4");

    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
